// File: rtl/tick_timer.sv
// Tick timer: synchronises a divided clock, turns its rising edges into one-cycle
// ticks and counts them down from a programmable period (one-shot or auto-reload).
module tick_timer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock_input,
    input  logic             reset,
    input  logic             slow_clock,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             error
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t                 state;
    state_t                 state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   tick_c;
    logic [WIDTH-1:0]       reload;
    logic [WIDTH-1:0]       reload_n;
    logic [WIDTH-1:0]       count_n;
    logic                   expired_n;
    logic                   error_n;

    // History flops reset high so a slow_clock already high at release is not an edge.
    always_ff @(posedge clock_input or posedge reset) begin
        if (reset) begin
            sync <= '1;
            prev <= 1'b1;
            tick <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], slow_clock};
            prev <= sync[SYNC_STAGES-1];
            tick <= tick_c;
        end
    end

    assign tick_c = sync[SYNC_STAGES-1] & ~prev;

    always_ff @(posedge clock_input or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            reload  <= '0;
            expired <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            reload  <= reload_n;
            expired <= expired_n;
            error   <= error_n;
        end
    end

    // Start is resolved first; stop then turns any resulting RUN into PAUSE.
    always_comb begin
        state_n   = state;
        count_n   = count;
        reload_n  = reload;
        expired_n = 1'b0;
        error_n   = error;
        if (load) begin
            error_n = 1'b0;
        end
        case (state)
            IDLE: begin
                if (load) begin
                    reload_n = period;
                    count_n  = period;
                end
                if (start) begin
                    if (reload_n != '0) begin
                        state_n = RUN;
                    end else begin
                        error_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (load) begin
                    reload_n = period;
                end
                if (tick_c) begin
                    if (count == ONE) begin
                        expired_n = 1'b1;
                        if (auto_reload) begin
                            count_n = reload;
                        end else begin
                            count_n = '0;
                            state_n = DONE;
                        end
                    end else if (count > ONE) begin
                        count_n = count - ONE;
                    end
                end
            end
            PAUSE: begin
                if (load) begin
                    reload_n = period;
                    count_n  = period;
                end
                if (start) begin
                    state_n = RUN;
                end
            end
            DONE: begin
                if (load) begin
                    reload_n = period;
                    count_n  = period;
                    state_n  = IDLE;
                end else if (start) begin
                    count_n = reload;
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
        if (stop && state_n == RUN) begin
            state_n = PAUSE;
        end
    end

    assign running = (state == RUN);

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed corner cases, a command table,
// and randomized traffic against a history-queue reference model.
module tb_tick_timer;

    localparam int S = 2;
    localparam int W = 8;

    logic         clock_input;
    logic         reset;
    logic         slow_clock;
    logic         load;
    logic [W-1:0] period;
    logic         start;
    logic         stop;
    logic         auto_reload;
    logic         tick;
    logic [W-1:0] count;
    logic         running;
    logic         expired;
    logic         error;

    int tests_run    = 0;
    int tests_failed = 0;

    tick_timer #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clock_input(clock_input),
        .reset(reset),
        .slow_clock(slow_clock),
        .load(load),
        .period(period),
        .start(start),
        .stop(stop),
        .auto_reload(auto_reload),
        .tick(tick),
        .count(count),
        .running(running),
        .expired(expired),
        .error(error)
    );

    initial clock_input = 1'b0;
    always #5 clock_input = ~clock_input;

    // Reference model: slow_clock samples kept newest-first; an edge is a high
    // sample S edges ago preceded by a low one.
    bit hist[$];
    int m_state;
    int m_count;
    int m_reload;
    bit m_tick;
    bit m_expired;
    bit m_error;

    always @(posedge clock_input or posedge reset) begin : model_blk
        bit edge_now;
        int old_reload;
        if (reset) begin
            hist.delete();
            for (int i = 0; i <= S; i++) hist.push_back(1'b1);
            m_state   = 0;
            m_count   = 0;
            m_reload  = 0;
            m_tick    = 0;
            m_expired = 0;
            m_error   = 0;
        end else begin
            edge_now = hist[S-1] && !hist[S];
            hist.push_front(slow_clock);
            void'(hist.pop_back());
            m_tick    = edge_now;
            m_expired = 0;
            if (load) m_error = 0;
            case (m_state)
                0: begin
                    if (load) begin
                        m_reload = int'(period);
                        m_count  = int'(period);
                    end
                    if (start) begin
                        if (m_reload == 0) m_error = 1;
                        else m_state = stop ? 2 : 1;
                    end
                end
                1: begin
                    old_reload = m_reload;
                    if (load) m_reload = int'(period);
                    if (edge_now && m_count == 1) begin
                        m_expired = 1;
                        if (auto_reload) begin
                            m_count = old_reload;
                            m_state = stop ? 2 : 1;
                        end else begin
                            m_count = 0;
                            m_state = 3;
                        end
                    end else begin
                        if (edge_now && m_count > 1) m_count = m_count - 1;
                        if (stop) m_state = 2;
                    end
                end
                2: begin
                    if (load) begin
                        m_reload = int'(period);
                        m_count  = int'(period);
                    end
                    if (start && !stop) m_state = 1;
                end
                default: begin
                    if (load) begin
                        m_reload = int'(period);
                        m_count  = int'(period);
                        m_state  = 0;
                    end else if (start) begin
                        m_count = m_reload;
                        m_state = stop ? 2 : 1;
                    end
                end
            endcase
        end
    end

    task automatic cyc();
        @(posedge clock_input);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic [W-1:0] p, input logic st,
                                 input logic sp, input logic ar);
        load        = l;
        period      = p;
        start       = st;
        stop        = sp;
        auto_reload = ar;
        cyc();
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // One slow_clock period: 4 cycles low then 4 high, recording what the tick showed.
    task automatic slowTick(output int ticks, output int exps, output int cnt, output int run);
        ticks = 0;
        exps  = 0;
        cnt   = -1;
        run   = -1;
        slow_clock = 1'b0;
        repeat (4) begin
            cyc();
            if (tick) ticks++;
            if (expired) exps++;
        end
        slow_clock = 1'b1;
        repeat (4) begin
            cyc();
            if (expired) exps++;
            if (tick) begin
                ticks++;
                cnt = int'(count);
                run = int'(running);
            end
        end
    endtask

    typedef struct {
        logic         ld;
        logic [W-1:0] per;
        logic         st;
        logic         sp;
        logic [W-1:0] ecount;
        logic         erun;
        logic         eerr;
    } vec_t;

    vec_t vecs[9];

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int tk, ex, cn, rn, phase_left;
        int exp_counts[6];
        int exp_exps[6];
        int total_exp;

        reset       = 1'b1;
        slow_clock  = 1'b1;
        load        = 1'b0;
        period      = '0;
        start       = 1'b0;
        stop        = 1'b0;
        auto_reload = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state and no spurious tick with slow_clock high at release
        checkOutput("reset_count", 32'(count), 0);
        checkOutput("reset_running", 32'(running), 0);
        checkOutput("reset_expired", 32'(expired), 0);
        checkOutput("reset_error", 32'(error), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            checkOutput("no_spurious_tick", 32'(tick), 0);
        end
        slow_clock = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checkOutput("tick_low_phase", 32'(tick), 0);
        end
        slow_clock = 1'b1;
        cyc();
        checkOutput("tick_e0", 32'(tick), 0);
        cyc();
        checkOutput("tick_e0p1", 32'(tick), 0);
        cyc();
        checkOutput("tick_e0p2", 32'(tick), 1);
        cyc();
        checkOutput("tick_e0p3", 32'(tick), 0);

        // One-shot, period 3
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("oneshot_start_count", 32'(count), 3);
        checkOutput("oneshot_start_running", 32'(running), 1);
        slowTick(tk, ex, cn, rn);
        checkOutput("oneshot_t1_count", cn, 2);
        checkOutput("oneshot_t1_exp", ex, 0);
        slowTick(tk, ex, cn, rn);
        checkOutput("oneshot_t2_count", cn, 1);
        checkOutput("oneshot_t2_exp", ex, 0);
        slowTick(tk, ex, cn, rn);
        checkOutput("oneshot_t3_count", cn, 0);
        checkOutput("oneshot_t3_exp", ex, 1);
        checkOutput("oneshot_t3_running", rn, 0);
        checkOutput("oneshot_done_running", 32'(running), 0);

        // Auto-reload, period 2, three expiries
        doReset();
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'd2, 1'b1, 1'b0, 1'b1);
        checkOutput("auto_start_count", 32'(count), 2);
        exp_counts = '{1, 2, 1, 2, 1, 2};
        exp_exps   = '{0, 1, 0, 1, 0, 1};
        total_exp  = 0;
        for (int i = 0; i < 6; i++) begin
            slowTick(tk, ex, cn, rn);
            total_exp += ex;
            checkOutput("auto_count", cn, exp_counts[i]);
            checkOutput("auto_exp", ex, exp_exps[i]);
            checkOutput("auto_running", rn, 1);
        end
        checkOutput("auto_total_exp", total_exp, 3);
        auto_reload = 1'b0;

        // Stop landing in the tick cycle
        doReset();
        applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("stop_start_count", 32'(count), 5);
        slow_clock = 1'b0;
        repeat (4) cyc();
        slow_clock = 1'b1;
        cyc();
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checkOutput("stop_tick", 32'(tick), 1);
        checkOutput("stop_count", 32'(count), 4);
        checkOutput("stop_running", 32'(running), 0);
        for (int i = 0; i < 3; i++) begin
            slowTick(tk, ex, cn, rn);
            checkOutput("pause_ticks_seen", tk, 1);
            checkOutput("pause_count", cn, 4);
        end
        applyStimulus(1'b0, 8'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("resume_running", 32'(running), 1);
        slowTick(tk, ex, cn, rn);
        checkOutput("resume_count", cn, 3);

        // Command table with slow_clock held high (no ticks)
        doReset();
        vecs[0] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 8'd7, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd7, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd7, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 8'd9, 1'b0, 1'b0, 8'd7, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'd4, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].ld, vecs[i].per, vecs[i].st, vecs[i].sp, 1'b0);
            checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecount));
            checkOutput($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].erun));
            checkOutput($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].eerr));
        end

        // Asynchronous reset mid-RUN
        doReset();
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("areset_pre_count", 32'(count), 2);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("areset_count", 32'(count), 0);
        checkOutput("areset_running", 32'(running), 0);
        checkOutput("areset_tick", 32'(tick), 0);
        checkOutput("areset_expired", 32'(expired), 0);
        checkOutput("areset_error", 32'(error), 0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            slowTick(tk, ex, cn, rn);
            checkOutput("areset_after_exp", ex, 0);
            checkOutput("areset_after_count", cn, 0);
        end

        // Randomized traffic against the reference model
        doReset();
        phase_left = 3;
        for (int i = 0; i < 3000; i++) begin
            load        = ($urandom % 16) == 0;
            period      = (($urandom % 8) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            start       = ($urandom % 6) == 0;
            stop        = ($urandom % 10) == 0;
            auto_reload = 1'($urandom % 2);
            if (phase_left == 0) begin
                slow_clock = ~slow_clock;
                phase_left = $urandom_range(2, 5);
            end
            phase_left--;
            cyc();
            checkOutput("rand_tick", 32'(tick), 32'(m_tick));
            checkOutput("rand_count", 32'(count), m_count);
            checkOutput("rand_running", 32'(running), (m_state == 1) ? 1 : 0);
            checkOutput("rand_expired", 32'(expired), 32'(m_expired));
            checkOutput("rand_error", 32'(error), 32'(m_error));
        end
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
